booth_norm_round: RTL and testbench

//  Downstream of the RGB fixed-point Booth multiplier. Accepts one frame of three unsigned 2.46 products (R, G, B).

---
 rtl/booth_norm_round.sv | 161 ++++++++++++++++
 tb/tb_booth_norm_round.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_norm_round.sv
// booth_norm_round
// Takes one frame of three unsigned 2.46 products (R, G, B) from the Booth
// multiplier. Each product is normalised to a 1.23 mantissa with an exponent
// adjust and then rounded. The three channels leave serially, R then G then B,
// over a valid/ready stream.
// Build option: define NORM_ROUND_RNE_EN for round-to-nearest-even.
// When the macro is not defined, the block truncates.
module booth_norm_round #(
  parameter int MANTISSA_WIDTH = 23,
  parameter int PROD_WIDTH     = 2*MANTISSA_WIDTH+2
) (
  input  logic                      clk_i_norm,
  input  logic                      rst_i_norm,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [PROD_WIDTH-1:0]     fixed_multiplication_result_Red_i,
  input  logic [PROD_WIDTH-1:0]     fixed_multiplication_result_Green_i,
  input  logic [PROD_WIDTH-1:0]     fixed_multiplication_result_Blue_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [1:0]                out_channel_o,
  output logic [MANTISSA_WIDTH:0]   out_mantissa_o,
  output logic [1:0]                out_exp_adj_o,
  output logic                      out_zero_o,
  output logic                      out_inexact_o,
  output logic                      frame_done_o
);

  localparam int MANT_W   = MANTISSA_WIDTH + 1;
  // Guard bit position when the product MSB is set. It is one lower otherwise.
  localparam int GUARD_HI = PROD_WIDTH - MANT_W - 1;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                state_q, state_nxt;
  logic [1:0]            ch_q;
  logic [PROD_WIDTH-1:0] prod_r_q, prod_g_q, prod_b_q;
  logic [MANT_W-1:0]     mant_q;
  logic [1:0]            exp_adj_q;
  logic                  zero_q, inexact_q;

  logic                  capture, transfer, last_ch;
  logic [PROD_WIDTH-1:0] prod_sel;
  logic [MANT_W-1:0]     mant_norm, mant_rnd;
  logic [MANT_W:0]       mant_sum;
  logic                  guard, sticky, rnd_inc;
  logic [1:0]            exp_norm, exp_rnd;

  assign capture  = (state_q == IDLE) && in_valid_i;
  assign transfer = (state_q == OUT) && out_ready_i;
  assign last_ch  = (ch_q == 2'd2);

  // Next-state logic for the IDLE -> CALC -> OUT word sequencer.
  always_comb begin
    // NOTE: the default assignment comes first, so every path assigns
    // state_nxt and no latch is inferred.
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i) state_nxt = CALC;
      CALC:    state_nxt = OUT;
      OUT:     if (out_ready_i) state_nxt = last_ch ? IDLE : CALC;
      default: state_nxt = IDLE;
    endcase
  end

  // Select the product that belongs to the current channel.
  always_comb begin
    prod_sel = prod_b_q;
    unique case (ch_q)
      2'd0:    prod_sel = prod_r_q;
      2'd1:    prod_sel = prod_g_q;
      default: prod_sel = prod_b_q;
    endcase
  end

  // Normalise to 1.23. The guard and sticky bits come from the bits that are
  // shifted out.
  always_comb begin
    if (prod_sel[PROD_WIDTH-1]) begin
      mant_norm = prod_sel[PROD_WIDTH-1 -: MANT_W];
      guard     = prod_sel[GUARD_HI];
      sticky    = |prod_sel[GUARD_HI-1:0];
      exp_norm  = 2'd1;
    end else begin
      // An input below 1.0 is illegal upstream. It still takes this path, with
      // no left shift.
      mant_norm = prod_sel[PROD_WIDTH-2 -: MANT_W];
      guard     = prod_sel[GUARD_HI-1];
      sticky    = |prod_sel[GUARD_HI-2:0];
      exp_norm  = 2'd0;
    end
  end

  // Round the mantissa. A carry out of the mantissa wraps to 1.0 and bumps
  // the exponent.
  always_comb begin
`ifdef NORM_ROUND_RNE_EN
    rnd_inc = guard && (sticky || mant_norm[0]);
`else
    rnd_inc = 1'b0;
`endif
    mant_sum = {1'b0, mant_norm} + {{MANT_W{1'b0}}, rnd_inc};
    if (mant_sum[MANT_W]) begin
      mant_rnd = {1'b1, {MANTISSA_WIDTH{1'b0}}};
      exp_rnd  = exp_norm + 2'd1;
    end else begin
      mant_rnd = mant_sum[MANT_W-1:0];
      exp_rnd  = exp_norm;
    end
  end

  // Product holding registers. They are only loaded on capture.
  // NOTE: these data registers are deliberately left without a reset. They are
  // never observed before a capture writes them, so a reset would only cost
  // area.
  always_ff @(posedge clk_i_norm) begin
    if (capture) begin
      prod_r_q <= fixed_multiplication_result_Red_i;
      prod_g_q <= fixed_multiplication_result_Green_i;
      prod_b_q <= fixed_multiplication_result_Blue_i;
    end
  end

  // Control state, channel counter and the registered output word.
  always_ff @(posedge clk_i_norm) begin
    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, whatever order the statements are in.
    if (rst_i_norm) begin
      state_q   <= IDLE;
      ch_q      <= 2'd0;
      mant_q    <= '0;
      exp_adj_q <= 2'd0;
      zero_q    <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (capture) begin
        ch_q <= 2'd0;
      end else if (transfer && !last_ch) begin
        ch_q <= ch_q + 2'd1;
      end
      if (state_q == CALC) begin
        mant_q    <= mant_rnd;
        exp_adj_q <= exp_rnd;
        zero_q    <= (prod_sel == '0);
        inexact_q <= guard | sticky;
      end
    end
  end

  assign in_ready_o     = (state_q == IDLE);
  assign out_valid_o    = (state_q == OUT);
  assign out_channel_o  = ch_q;
  assign out_mantissa_o = mant_q;
  assign out_exp_adj_o  = exp_adj_q;
  assign out_zero_o     = zero_q;
  assign out_inexact_o  = inexact_q;
  // The frame ends in the same cycle the B word is accepted. A reset suppresses it.
  assign frame_done_o   = transfer && last_ch && !rst_i_norm;

endmodule

// File: tb/tb_booth_norm_round.sv
// tb_booth_norm_round
// Scoreboard bench for booth_norm_round. It follows NORM_ROUND_RNE_EN in the
// same way as the design.
module tb_booth_norm_round;

  localparam int MW = 23;
  localparam int PW = 2*MW+2;

  logic          clk_i_norm = 1'b0;
  logic          rst_i_norm;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [PW-1:0] fixed_multiplication_result_Red_i;
  logic [PW-1:0] fixed_multiplication_result_Green_i;
  logic [PW-1:0] fixed_multiplication_result_Blue_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [1:0]    out_channel_o;
  logic [MW:0]   out_mantissa_o;
  logic [1:0]    out_exp_adj_o;
  logic          out_zero_o;
  logic          out_inexact_o;
  logic          frame_done_o;

  booth_norm_round #(.MANTISSA_WIDTH(MW)) dut (
    .clk_i_norm                          (clk_i_norm),
    .rst_i_norm                          (rst_i_norm),
    .in_valid_i                          (in_valid_i),
    .in_ready_o                          (in_ready_o),
    .fixed_multiplication_result_Red_i   (fixed_multiplication_result_Red_i),
    .fixed_multiplication_result_Green_i (fixed_multiplication_result_Green_i),
    .fixed_multiplication_result_Blue_i  (fixed_multiplication_result_Blue_i),
    .out_valid_o                         (out_valid_o),
    .out_ready_i                         (out_ready_i),
    .out_channel_o                       (out_channel_o),
    .out_mantissa_o                      (out_mantissa_o),
    .out_exp_adj_o                       (out_exp_adj_o),
    .out_zero_o                          (out_zero_o),
    .out_inexact_o                       (out_inexact_o),
    .frame_done_o                        (frame_done_o)
  );

  always #5 clk_i_norm = ~clk_i_norm;

  typedef struct {
    logic [1:0]  ch;
    logic [MW:0] mant;
    logic [1:0]  ea;
    logic        z;
    logic        inx;
  } word_t;

  word_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    done_cnt = 0;
  int    frames_expected = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model. It uses the shift, the remainder and the half-ulp of
  // the discarded bits.
  function automatic word_t model(input logic [1:0] ch, input logic [PW-1:0] p);
    word_t       w;
    int          sh;
    logic [PW:0] m, rem, half;
    sh   = p[PW-1] ? MW+1 : MW;
    m    = {1'b0, p} >> sh;
    rem  = {1'b0, p} & ((49'd1 << sh) - 49'd1);
    half = 49'd1 << (sh - 1);
    w.ch  = ch;
    w.ea  = p[PW-1] ? 2'd1 : 2'd0;
    w.z   = (p == '0);
    w.inx = (rem != 0);
`ifdef NORM_ROUND_RNE_EN
    if (rem > half || (rem == half && m[0])) m = m + 49'd1;
    if (m == (49'd1 << (MW+1))) begin
      m    = m >> 1;
      w.ea = w.ea + 2'd1;
    end
`endif
    w.mant = m[MW:0];
    return w;
  endfunction

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk_i_norm) begin
    if (!rst_i_norm) begin
      if (frame_done_o) done_cnt++;
      if (frame_done_o && !(out_valid_o && out_ready_i))
        check("done_without_xfer", 64'(frame_done_o), 64'd0);
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          word_t e;
          e = sb.pop_front();
          check("chan",    64'(out_channel_o),  64'(e.ch));
          check("mant",    64'(out_mantissa_o), 64'(e.mant));
          check("exp_adj", 64'(out_exp_adj_o),  64'(e.ea));
          check("zero",    64'(out_zero_o),     64'(e.z));
          check("inexact", 64'(out_inexact_o),  64'(e.inx));
          check("done_on_xfer", 64'(frame_done_o), 64'(e.ch == 2'd2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i_norm);
    #1;
  endtask

  task automatic send_frame(input logic [PW-1:0] r, input logic [PW-1:0] g, input logic [PW-1:0] b);
    int n;
    n = 0;
    while (!in_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1;
    fixed_multiplication_result_Red_i   = r;
    fixed_multiplication_result_Green_i = g;
    fixed_multiplication_result_Blue_i  = b;
    sb.push_back(model(2'd0, r));
    sb.push_back(model(2'd1, g));
    sb.push_back(model(2'd2, b));
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_i_norm);
      if (frame_done_o) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
    frames_expected++;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i_norm);
      if (out_valid_o) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  localparam logic [PW-1:0] P_R = 48'h57E4_0000_0000;
  localparam logic [PW-1:0] P_G = 48'h6400_0000_0000;
  localparam logic [PW-1:0] P_B = 48'h70E4_0000_0000;

  initial begin
    word_t wg;
    int    cyc;
    bit    seen;
    logic [63:0] rnd;

    rst_i_norm  = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    fixed_multiplication_result_Red_i   = '0;
    fixed_multiplication_result_Green_i = '0;
    fixed_multiplication_result_Blue_i  = '0;
    repeat (3) tick();
    rst_i_norm = 1'b0;
    @(negedge clk_i_norm);
    check("rst_in_ready", 64'(in_ready_o),     64'd1);
    check("rst_valid",    64'(out_valid_o),    64'd0);
    check("rst_chan",     64'(out_channel_o),  64'd0);
    check("rst_mant",     64'(out_mantissa_o), 64'd0);
    check("rst_exp",      64'(out_exp_adj_o),  64'd0);
    check("rst_zero",     64'(out_zero_o),     64'd0);
    check("rst_inexact",  64'(out_inexact_o),  64'd0);
    check("rst_done",     64'(frame_done_o),   64'd0);

    // Frame 1: the reference vectors. This frame also checks latency and frame length.
    tick();
    out_ready_i = 1'b1;
    send_frame(P_R, P_G, P_B);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk_i_norm);
      cyc++;
      if (cyc == 1) check("lat_calc_not_valid", 64'(out_valid_o), 64'd0);
      if (cyc == 2) check("lat_first_valid",    64'(out_valid_o), 64'd1);
      if (frame_done_o) seen = 1'b1;
    end
    check("frame_cycles", 64'(cyc), 64'd6);
    frames_expected++;

    // Rounding ties, round-down and mantissa carry-out.
    tick();
    send_frame(48'h8000_0180_0000, 48'h8000_0080_0000, 48'hFFFF_FFC0_0000);
    wait_done("done_round");

    // Zero, sticky-only, exact 1.0, and an illegal input below 1.0.
    tick();
    send_frame(48'h0, 48'hFFFF_FE00_0001, 48'h4000_0000_0000);
    wait_done("done_zero");
    tick();
    send_frame(48'h2000_0000_0001, 48'hC000_0000_0000, 48'h7FFF_FFFF_FFFF);
    wait_done("done_small");

    // Random products.
    for (int f = 0; f < 4; f++) begin
      logic [PW-1:0] pr, pg, pb;
      rnd = {$urandom(), $urandom()}; pr = rnd[PW-1:0];
      rnd = {$urandom(), $urandom()}; pg = rnd[PW-1:0];
      rnd = {$urandom(), $urandom()}; pb = rnd[PW-1:0];
      tick();
      send_frame(pr, pg, pb);
      wait_done("done_rand");
    end

    // Backpressure on the G word.
    tick();
    out_ready_i = 1'b0;
    send_frame(P_R, P_G, P_B);
    wait_valid("bp_r_valid");
    tick();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    wait_valid("bp_g_valid");
    wg = model(2'd1, P_G);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i_norm);
      check("bp_hold_valid", 64'(out_valid_o),    64'd1);
      check("bp_hold_chan",  64'(out_channel_o),  64'd1);
      check("bp_hold_mant",  64'(out_mantissa_o), 64'(wg.mant));
      check("bp_hold_exp",   64'(out_exp_adj_o),  64'(wg.ea));
    end
    tick();
    out_ready_i = 1'b1;
    @(negedge clk_i_norm);
    @(negedge clk_i_norm);
    check("bp_gap_not_valid", 64'(out_valid_o), 64'd0);
    @(negedge clk_i_norm);
    check("bp_b_valid", 64'(out_valid_o),   64'd1);
    check("bp_b_chan",  64'(out_channel_o), 64'd2);
    check("bp_b_done",  64'(frame_done_o),  64'd1);
    frames_expected++;

    // Reset while the G word is being presented.
    tick();
    out_ready_i = 1'b0;
    send_frame(48'h8000_0180_0000, P_G, P_B);
    wait_valid("rst_r_valid");
    tick();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    wait_valid("rst_g_valid");
    check("rst_g_chan", 64'(out_channel_o), 64'd1);
    cyc = done_cnt;
    tick();
    rst_i_norm = 1'b1;
    tick();
    rst_i_norm = 1'b0;
    @(negedge clk_i_norm);
    check("midrst_valid",    64'(out_valid_o),  64'd0);
    check("midrst_in_ready", 64'(in_ready_o),   64'd1);
    check("midrst_done",     64'(frame_done_o), 64'd0);
    check("midrst_no_pulse", 64'(done_cnt),     64'(cyc));
    sb.delete();
    tick();
    out_ready_i = 1'b1;
    send_frame(P_B, 48'h8000_0080_0000, 48'h0);
    wait_done("done_after_rst");

    repeat (3) tick();
    check("sb_drained", 64'(sb.size()),  64'd0);
    check("done_count", 64'(done_cnt),   64'(frames_expected));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
